// File: rtl/mux_t_sel_sched.sv
// Round-robin scheduler sharing one temporal mux: the granted index is encoded as the
// rising-edge time of select_line within a gamma cycle, and the sampled mux output is returned.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | no grant for the current gamma cycle, select_line held low
// S_BUSY | serving cur_id, select_line encodes cur_idx, sample y at G-1
module mux_t_sel_sched #(
   parameter int GAMMA_CYCLE_WIDTH = 16,
   parameter int NUM_INPUTS        = 14,
   parameter int NUM_REQ           = 4,
   parameter int BUS_WIDTH         = 8,
   parameter int IDX_WIDTH         = $clog2(GAMMA_CYCLE_WIDTH),
   parameter int ID_WIDTH          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                               aclk,
   input  logic                               grst,
   input  logic [NUM_REQ-1:0]                 req,
   input  logic [NUM_REQ-1:0][IDX_WIDTH-1:0]  req_idx,
   output logic [NUM_REQ-1:0]                 gnt,
   output logic                               select_line,
   output logic                               mux_clr,
   input  logic [BUS_WIDTH-1:0]               y,
   output logic                               rsp_valid,
   output logic [ID_WIDTH-1:0]                rsp_id,
   output logic [BUS_WIDTH-1:0]               rsp_data,
   output logic                               rsp_err,
   output logic                               gamma_start
);

   localparam logic [IDX_WIDTH-1:0] LAST_SLOT = IDX_WIDTH'(GAMMA_CYCLE_WIDTH - 1);
   localparam logic [IDX_WIDTH-1:0] IDX_LIMIT = IDX_WIDTH'(NUM_INPUTS);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t                 state, state_nxt;
   logic [IDX_WIDTH-1:0]   cnt;
   logic [ID_WIDTH-1:0]    rr_ptr;
   logic [ID_WIDTH-1:0]    cur_id;
   logic [IDX_WIDTH-1:0]   cur_idx;
   logic [NUM_REQ-1:0]     gnt_q;
   logic                   rsp_valid_q;
   logic [ID_WIDTH-1:0]    rsp_id_q;
   logic [BUS_WIDTH-1:0]   rsp_data_q;
   logic                   rsp_err_q;

   logic                   last_slot;
   logic                   idx_err;
   logic                   any_req;
   logic [ID_WIDTH-1:0]    win;
   logic [ID_WIDTH-1:0]    j_id;
   logic [NUM_REQ-1:0]     win_oh;
   logic [ID_WIDTH-1:0]    ptr_nxt;

   assign last_slot = (cnt == LAST_SLOT);
   assign idx_err   = (cur_idx >= IDX_LIMIT);
   assign ptr_nxt   = ID_WIDTH'((int'(win) + 1) % NUM_REQ);

   // Search starts at rr_ptr and wraps, first asserted request wins.
   always_comb begin
      any_req = 1'b0;
      win     = '0;
      win_oh  = '0;
      j_id    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         j_id = ID_WIDTH'((int'(rr_ptr) + i) % NUM_REQ);
         if (!any_req && req[j_id]) begin
            any_req      = 1'b1;
            win          = j_id;
            win_oh       = '0;
            win_oh[j_id] = 1'b1;
         end
      end
   end

   always_ff @(posedge aclk) begin
      if (grst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (last_slot) state_nxt = any_req ? S_BUSY : S_IDLE;
   end

   always_ff @(posedge aclk) begin
      if (grst) begin
         cnt         <= '0;
         rr_ptr      <= '0;
         cur_id      <= '0;
         cur_idx     <= '0;
         gnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         cnt         <= last_slot ? '0 : cnt + 1'b1;
         gnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         if (last_slot) begin
            if (any_req) begin
               gnt_q   <= win_oh;
               cur_id  <= win;
               cur_idx <= req_idx[win];
               rr_ptr  <= ptr_nxt;
            end
            // Response for the gamma cycle that is just ending; cur_* still hold its request.
            if (state == S_BUSY) begin
               rsp_valid_q <= 1'b1;
               rsp_id_q    <= cur_id;
               rsp_err_q   <= idx_err;
               rsp_data_q  <= idx_err ? '0 : y;
            end
         end
      end
   end

   // Outputs are forced to reset values the moment grst is seen, not just after the edge.
   always_comb begin
      gnt         = '0;
      select_line = 1'b0;
      mux_clr     = 1'b1;
      gamma_start = 1'b0;
      rsp_valid   = 1'b0;
      rsp_id      = '0;
      rsp_data    = '0;
      rsp_err     = 1'b0;
      if (!grst) begin
         gnt         = gnt_q;
         mux_clr     = (cnt == '0);
         gamma_start = (cnt == '0);
         select_line = (state == S_BUSY) && !idx_err && (cnt > cur_idx);
         rsp_valid   = rsp_valid_q;
         rsp_id      = rsp_id_q;
         rsp_data    = rsp_data_q;
         rsp_err     = rsp_err_q;
      end
   end

endmodule

// File: tb/tb_mux_t_sel_sched.sv
// Scoreboard bench for mux_t_sel_sched: directed requests queue expected grants, select
// edges and responses; a negedge monitor pops and compares whenever the DUT presents one.
module tb_mux_t_sel_sched;

   localparam int G   = 16;
   localparam int NR  = 4;
   localparam int BW  = 8;
   localparam int IW  = 4;
   localparam int IDW = 2;

   logic                  aclk = 1'b0;
   logic                  grst = 1'b1;
   logic [NR-1:0]         req = '0;
   logic [NR-1:0][IW-1:0] req_idx = '0;
   logic [NR-1:0]         gnt;
   logic                  select_line, mux_clr, gamma_start;
   logic [BW-1:0]         y;
   logic                  rsp_valid;
   logic [IDW-1:0]        rsp_id;
   logic [BW-1:0]         rsp_data;
   logic                  rsp_err;

   mux_t_sel_sched #(
      .GAMMA_CYCLE_WIDTH(G), .NUM_INPUTS(14), .NUM_REQ(NR), .BUS_WIDTH(BW)
   ) dut (
      .aclk(aclk), .grst(grst), .req(req), .req_idx(req_idx), .gnt(gnt),
      .select_line(select_line), .mux_clr(mux_clr), .y(y), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .gamma_start(gamma_start)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      int id;
      int data;
      int err;
   } rsp_t;

   int   checks   = 0;
   int   failures = 0;
   rsp_t exp_rsp[$];
   int   exp_gnt[$];
   int   exp_rise[$];
   int   left[NR];
   int   cyc = 0;
   logic prev_sel = 1'b0;
   logic ovl_seen = 1'b0;

   task automatic check(input string name, input int act, input int want);
      checks++;
      if (act != want) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, want, $time);
      end
   endtask

   // Temporal mux model with inputs[i]=i: output follows the first select edge after a clear.
   int   mcnt;
   logic seen;
   always @(posedge aclk) begin
      if (mux_clr) begin
         mcnt <= 1;
         seen <= 1'b0;
         y    <= 8'hEE;
      end else begin
         mcnt <= mcnt + 1;
         if (select_line && !seen) begin
            seen <= 1'b1;
            y    <= BW'(mcnt - 1);
         end
      end
   end

   // Independent gamma position: cycle 0 is the first cycle with grst low.
   always @(posedge aclk) cyc <= grst ? 0 : cyc + 1;

   always @(negedge aclk) begin
      int   pos;
      int   e;
      rsp_t r;
      if (grst) begin
         check("reset_outputs",
               int'({gnt, select_line, rsp_valid, rsp_id, rsp_data, rsp_err, mux_clr, gamma_start}), 2);
         prev_sel = 1'b0;
      end else begin
         pos = cyc % G;
         check("gamma_start", int'(gamma_start), int'(pos == 0));
         check("mux_clr", int'(mux_clr), int'(pos == 0));
         if (gnt != '0) begin
            if (exp_gnt.size() == 0) check("gnt_unexpected", int'(gnt), 0);
            else begin
               e = exp_gnt.pop_front();
               check("gnt_vec", int'(gnt), 1 << e);
               check("gnt_slot", pos, 0);
            end
         end
         if (select_line && !prev_sel) begin
            if (exp_rise.size() == 0) check("select_unexpected", pos, -1);
            else begin
               e = exp_rise.pop_front();
               check("select_rise_cnt", pos, e);
            end
         end
         if (rsp_valid) begin
            if (exp_rsp.size() == 0) check("rsp_unexpected", int'(rsp_valid), 0);
            else begin
               r = exp_rsp.pop_front();
               check("rsp_id", int'(rsp_id), r.id);
               check("rsp_data", int'(rsp_data), r.data);
               check("rsp_err", int'(rsp_err), r.err);
               check("rsp_slot", pos, 0);
            end
         end
         if (rsp_valid && rsp_id == 2'd0 && gnt[1]) ovl_seen = 1'b1;
         prev_sel = select_line;
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_reset(input int n);
      grst = 1'b1;
      req  = '0;
      repeat (n) tick();
      grst = 1'b0;
   endtask

   task automatic push(input int id, input int idx, input int data, input int err);
      rsp_t r;
      exp_gnt.push_back(id);
      if (err == 0) exp_rise.push_back(idx + 1);
      r.id = id; r.data = data; r.err = err;
      exp_rsp.push_back(r);
   endtask

   // Drops each requester's req once it has received left[r] grants; checks no idle gaps.
   task automatic run(input int budget);
      int remaining;
      int last_g;
      last_g = -1;
      for (int k = 0; k < budget; k++) begin
         tick();
         if (gnt != '0) begin
            if (last_g >= 0) check("grant_gap", cyc - last_g, G);
            last_g = cyc;
         end
         remaining = 0;
         for (int r = 0; r < NR; r++) begin
            if (gnt[r] && left[r] > 0) begin
               left[r]--;
               if (left[r] == 0) req[r] = 1'b0;
            end
            remaining += left[r];
         end
         if (remaining == 0) break;
      end
      remaining = 0;
      for (int r = 0; r < NR; r++) remaining += left[r];
      check("run_grants_outstanding", remaining, 0);
   endtask

   initial begin
      do_reset(3);

      // Single request: requester 2, idx 10
      push(2, 10, 10, 0);
      req_idx[2] = 4'd10;
      req[2]     = 1'b1;
      repeat (16) tick();
      check("single_gnt_at_cycle16", int'(gnt), 4'b0100);
      req[2] = 1'b0;
      repeat (16) tick();
      check("single_rsp_at_cycle32", int'({rsp_valid, rsp_id}), int'({1'b1, 2'd2}));
      repeat (G) tick();

      // Round-robin: all four hold, requester 0 comes back after the others
      do_reset(2);
      push(0, 0, 0, 0); push(1, 1, 1, 0); push(2, 2, 2, 0); push(3, 3, 3, 0); push(0, 0, 0, 0);
      for (int r = 0; r < NR; r++) begin
         req_idx[r] = IW'(r);
         left[r]    = 1;
      end
      left[0] = 2;
      req     = 4'hF;
      run(7 * G);
      repeat (2 * G) tick();

      // Index boundaries
      do_reset(2);
      push(0, 0, 0, 0);
      req_idx[0] = 4'd0;  req[0] = 1'b1; left[0] = 1; run(3 * G);
      push(0, 13, 13, 0);
      req_idx[0] = 4'd13; req[0] = 1'b1; left[0] = 1; run(3 * G);
      push(0, 14, 0, 1);
      req_idx[0] = 4'd14; req[0] = 1'b1; left[0] = 1; run(3 * G);
      repeat (2 * G) tick();

      // Idle gaps: one request, then long silence
      do_reset(2);
      push(1, 7, 7, 0);
      req_idx[1] = 4'd7; req[1] = 1'b1; left[1] = 1; run(3 * G);
      repeat (6 * G) tick();

      // Reset mid-operation at cnt=12 of an active gamma cycle
      do_reset(2);
      exp_gnt.push_back(2);
      exp_rise.push_back(6);
      req_idx[2] = 4'd5; req[2] = 1'b1;
      repeat (16) tick();
      req[2] = 1'b0;
      repeat (12) tick();
      check("pre_reset_cnt12", cyc % G, 12);
      do_reset(2);
      push(1, 10, 10, 0);
      push(3, 10, 10, 0);
      req_idx[1] = 4'd10; req_idx[3] = 4'd10;
      req[1] = 1'b1; req[3] = 1'b1;
      repeat (16) tick();
      check("post_reset_gnt_priority", int'(gnt), 4'b0010);
      req[1] = 1'b0;
      repeat (16) tick();
      check("post_reset_rsp", int'({rsp_valid, rsp_id}), int'({1'b1, 2'd1}));
      check("post_reset_second_gnt", int'(gnt), 4'b1000);
      req[3] = 1'b0;
      repeat (2 * G) tick();

      // Overlap: response for requester 0 and grant to requester 1 in the same cycle
      do_reset(2);
      ovl_seen = 1'b0;
      push(0, 3, 3, 0); push(1, 4, 4, 0);
      req_idx[0] = 4'd3; req_idx[1] = 4'd4;
      left[0] = 1; left[1] = 1; left[2] = 0; left[3] = 0;
      req = 4'b0011;
      run(4 * G);
      repeat (2 * G) tick();
      check("overlap_rsp0_gnt1", int'(ovl_seen), 1);

      check("gnt_queue_drained", exp_gnt.size(), 0);
      check("rise_queue_drained", exp_rise.size(), 0);
      check("rsp_queue_drained", exp_rsp.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mux_t_sel_sched.md
# mux_t_sel_sched

Scheduler that shares one temporal mux (`mux_b_t_s`) among several requesters. Each requester asks for an input index in binary. The block arbitrates round-robin, granting at most one request per gamma cycle. It encodes the granted index as the rising-edge time of `select_line` within the gamma cycle, clears the mux between gamma cycles, and returns the mux output to the winner. It sits between the binary-domain requesters and the temporal mux datapath.

## Interface
- `GAMMA_CYCLE_WIDTH`, 16: clocks per gamma cycle (≥4).
- `NUM_INPUTS`, 14: mux inputs; must be ≤ `GAMMA_CYCLE_WIDTH`-2.
- `NUM_REQ`, 4: number of requesters (≥1).
- `BUS_WIDTH`, 8: mux data width.
- `IDX_WIDTH`, $clog2(`GAMMA_CYCLE_WIDTH`): width of the index field.
- `aclk` in 1: the single clock; all logic on posedge.
- `grst` in 1: reset, synchronous and active-high.
- `req` in [NUM_REQ]: request per requester; held until its `gnt`.
- `req_idx` in [NUM_REQ][IDX_WIDTH]: requested mux input; held with `req`.
- `gnt` out [NUM_REQ]: one-hot grant pulse.
- `select_line` out 1: temporal select to the mux.
- `mux_clr` out 1: clear strobe to the mux (drives the mux `grst`).
- `y` in [BUS_WIDTH]: mux output.
- `rsp_valid` out 1: response pulse.
- `rsp_id` out $clog2(NUM_REQ) (min 1): requester the response belongs to.
- `rsp_data` out [BUS_WIDTH]: sampled mux output.
- `rsp_err` out 1: requested index was out of range.
- `gamma_start` out 1: high when cnt==0.

## Operation
- **Gamma counter `cnt`.** Free-running 0..G-1, wrapping to 0 (G = `GAMMA_CYCLE_WIDTH`).
- **Slot 0 (cnt==0).**
  - `mux_clr`=1 and `gamma_start`=1.
  - `select_line`=0.
- **Arbitration at cnt==G-1.**
  - Sample `req` and pick a winner round-robin, starting from (last winner + 1) mod NUM_REQ. After reset the search starts at requester 0.
  - If any requester wins, latch `active`=1, `cur_id`, and `cur_idx` = `req_idx[winner]` on the G-1→0 edge.
  - Otherwise latch `active`=0.
  - The round-robin pointer updates only on a grant.
- **Grant.** `gnt[winner]`=1 for exactly the cnt==0 cycle of the granted gamma cycle. The requester may drop `req` or present a new index from the next cycle.
- **Select encoding** (valid only while `active`=1 and `cur_idx` < NUM_INPUTS):
  - `select_line`=1 for every cycle with cnt ≥ `cur_idx`+1.
  - `select_line`=0 otherwise.
  - The rising edge therefore occurs at cnt = `cur_idx`+1, in the range 1..NUM_INPUTS.
- **Out-of-range index** (`cur_idx` ≥ NUM_INPUTS):
  - The request is still granted.
  - `select_line` stays 0 for the whole gamma cycle.
  - The response carries `rsp_err`=1 and `rsp_data`=0.
- **Sampling.** On the clock edge ending cnt==G-1 of an active gamma cycle, capture `y` into `rsp_data`, and capture `cur_id` and the error flag.
- **Response.** `rsp_valid`=1 during the cnt==0 cycle of the following gamma cycle. `rsp_id`, `rsp_data` and `rsp_err` are valid with it and hold until the next response.
- **Idle gamma cycle** (`active`=0): `select_line`=0 throughout, and no response follows.
- **Simultaneous events.** In the same cnt==0 cycle, the response for gamma cycle N and the grant for gamma cycle N+1 may both assert. Both are legal and independent.
- **Throughput.** One request per gamma cycle, with a 100% duty cycle when requests are back-to-back.

## Timing
- **While `grst`=1:**
  - cnt=0, `active`=0, round-robin pointer at requester 0.
  - `gnt`=0, `select_line`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_data`=0, `rsp_err`=0.
  - `mux_clr`=1 and `gamma_start`=0.
- **First cycle after `grst` falls:** cnt=0, so `mux_clr`=1 and `gamma_start`=1. Gamma cycle 0 is always idle.
- **Request to grant.** A request present at cnt==G-1 of cycle N is granted at cnt==0 of cycle N+1.
- **Grant to response.** The response follows exactly G clocks after the grant.
- **Request to response.** A request sampled at cnt==G-1 produces `rsp_valid` G+1 clocks later.
- **Mid-operation reset.** Any cycle with `grst`=1 aborts the in-flight gamma cycle:
  - No response is produced for it.
  - The pending grant is discarded.
  - All state returns to reset values on the next edge.
- **Late or dropped requests.** `req` changes at any cnt other than G-1 have no effect until the next G-1 sample.

## Test plan
- **Single request.** Mux `inputs[i]`=i. Requester 2 requests idx 10 after reset.
  - `gnt[2]` pulses at the start of gamma cycle 1.
  - `select_line` rises at cnt=11.
  - At the start of gamma cycle 2: `rsp_valid`=1, `rsp_id`=2, `rsp_data`=10, `rsp_err`=0.
- **Round-robin.** All 4 requesters hold `req` with idx 0, 1, 2, 3.
  - Grants arrive in order 0, 1, 2, 3, 0 on consecutive gamma cycles.
  - Responses return `rsp_data` 0, 1, 2, 3 in the same order.
  - No gamma cycle is idle.
- **Index boundaries.**
  - idx 0: `select_line` rises at cnt=1, `rsp_data`=0.
  - idx 13: rises at cnt=14, `rsp_data`=13.
  - idx 14: `select_line` stays 0, `rsp_err`=1, `rsp_data`=0.
- **Idle gaps.** Requester 1 requests once, then nothing.
  - Exactly one grant and one response.
  - Afterwards `select_line` stays 0, `rsp_valid` stays 0, and `mux_clr` pulses every 16 clocks.
- **Reset mid-operation.** Assert `grst` for 2 clocks at cnt=12 of an active gamma cycle with idx 5.
  - No `rsp_valid` for that request.
  - The next request is granted starting from requester 0 priority, with the timing of the single-request test.
- **Overlap.** Back-to-back requests from requesters 0 and 1.
  - In the same cycle, `rsp_valid` with `rsp_id`=0 and `gnt[1]` both assert.
